output_thresh_tile: RTL

- Parametrised successor to the fixed 4x4 output thresholder.
- Snapshots an N-pixel tile of IN_W-bit filter results on start, then judges LANES pixels per enabled cycle against a runtime threshold.
- Produces OUT_W-bit output pixels, a foreground-pixel count and the SRAM write address for the tile.
- Sits between the convolution core and the SRAM write controller.

---
 rtl/output_thresh_pkg.sv | 25 ++
 rtl/output_thresh_tile_if.sv | 43 ++++
 rtl/output_thresh_lane.sv | 36 +++
 rtl/output_thresh_tile.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/output_thresh_pkg.sv
// rtl/output_thresh_pkg.sv - shared state type, address offset default and popcount helper
package output_thresh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_JUDGE = 2'd1,
    ST_CALC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned ADDR_OFFSET_DEFAULT = 1602;

  // Widest lane-hit vector the popcount helper accepts (LANES must not exceed it).
  localparam int POPCNT_W = 64;

  function automatic int unsigned popcount(input logic [POPCNT_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POPCNT_W; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/output_thresh_tile_if.sv
// rtl/output_thresh_tile_if.sv - request/result bundle between tile producer and thresholder
interface output_thresh_tile_if #(
  parameter int TILE_W = 4,
  parameter int TILE_H = 4,
  parameter int IN_W   = 18,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 32
);
  localparam int NPIX  = TILE_W * TILE_H;
  localparam int CNT_W = $clog2(NPIX + 1);

  logic                                    start;
  logic                                    calc_en;
  logic [TILE_H-1:0][TILE_W-1:0][IN_W-1:0] data_in;
  logic [IN_W-1:0]                         threshold;
  logic [ADDR_W-1:0]                       start_addr;
  logic [ADDR_W-1:0]                       addr_calc_addr;
`ifdef OUTPUT_THRESH_TILE_CLAMP_EN
  logic                                    mode;
`endif
  logic [TILE_H-1:0][TILE_W-1:0][OUT_W-1:0] data_o;
  logic [ADDR_W-1:0]                        calc_addr;
  logic [CNT_W-1:0]                         fg_count;
  logic                                     busy;
  logic                                     calc_done;

  modport master (
    output start, calc_en, data_in, threshold, start_addr, addr_calc_addr,
`ifdef OUTPUT_THRESH_TILE_CLAMP_EN
    output mode,
`endif
    input  data_o, calc_addr, fg_count, busy, calc_done
  );

  modport slave (
    input  start, calc_en, data_in, threshold, start_addr, addr_calc_addr,
`ifdef OUTPUT_THRESH_TILE_CLAMP_EN
    input  mode,
`endif
    output data_o, calc_addr, fg_count, busy, calc_done
  );

endinterface

// File: rtl/output_thresh_lane.sv
// rtl/output_thresh_lane.sv - single-pixel judge; OUTPUT_THRESH_TILE_CLAMP_EN adds saturating shift mode
module output_thresh_lane #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 8
`ifdef OUTPUT_THRESH_TILE_CLAMP_EN
  ,
  parameter int CLAMP_SHIFT = 4
`endif
) (
  input  logic [IN_W-1:0]  pixel_i,
  input  logic [IN_W-1:0]  threshold_i,
`ifdef OUTPUT_THRESH_TILE_CLAMP_EN
  input  logic             mode_i,
`endif
  output logic [OUT_W-1:0] pix_o,
  output logic             hit_o
);

  // Strict unsigned compare: a pixel equal to the threshold is background.
  assign hit_o = (pixel_i > threshold_i);

`ifdef OUTPUT_THRESH_TILE_CLAMP_EN
  logic [IN_W-1:0]  shifted;
  logic             sat;
  logic [OUT_W-1:0] clamped;

  // Any bit left above OUT_W after the shift means the value does not fit: saturate.
  assign shifted = pixel_i >> CLAMP_SHIFT;
  assign sat     = |(shifted >> OUT_W);
  assign clamped = sat ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
  assign pix_o   = mode_i ? clamped : {OUT_W{hit_o}};
`else
  assign pix_o   = {OUT_W{hit_o}};
`endif

endmodule

// File: rtl/output_thresh_tile.sv
// rtl/output_thresh_tile.sv - tile thresholder top; OUTPUT_THRESH_TILE_CLAMP_EN enables clamp mode
module output_thresh_tile
  import output_thresh_pkg::*;
#(
  parameter int          TILE_W      = 4,
  parameter int          TILE_H      = 4,
  parameter int          IN_W        = 18,
  parameter int          OUT_W       = 8,
  parameter int          LANES       = 1,
  parameter int          ADDR_W      = 32,
  parameter int unsigned ADDR_OFFSET = ADDR_OFFSET_DEFAULT
`ifdef OUTPUT_THRESH_TILE_CLAMP_EN
  ,
  parameter int          CLAMP_SHIFT = 4
`endif
) (
  input logic                clk,
  input logic                rst,
  output_thresh_tile_if.slave bus
);

  localparam int NPIX  = TILE_W * TILE_H;
  localparam int NSTEP = NPIX / LANES;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int IW    = $clog2(NPIX) + 1;

  // Shadow copies of the request; the inputs are free to change once accepted.
  logic [NPIX*IN_W-1:0] din_q;
  logic [IN_W-1:0]      thr_q;
  logic [ADDR_W-1:0]    sa_q;
  logic [ADDR_W-1:0]    aca_q;
`ifdef OUTPUT_THRESH_TILE_CLAMP_EN
  logic                 mode_q;
`endif

  state_t                state_q;
  logic [SW-1:0]         step_q;
  logic [NPIX*OUT_W-1:0] data_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  done_q;

  logic [IW-1:0]         pix_idx [LANES];
  logic [OUT_W-1:0]      lane_pix [LANES];
  logic [LANES-1:0]      hits;
  logic [CNT_W-1:0]      cnt_d;
  logic [ADDR_W-1:0]     addr_d;

  // Each lane judges one pixel of the current step, row-major order.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign pix_idx[l] = IW'(step_q) * IW'(LANES) + IW'(l);

    output_thresh_lane #(
      .IN_W        (IN_W),
      .OUT_W       (OUT_W)
`ifdef OUTPUT_THRESH_TILE_CLAMP_EN
      ,
      .CLAMP_SHIFT (CLAMP_SHIFT)
`endif
    ) u_lane (
      .pixel_i     (din_q[pix_idx[l]*IN_W +: IN_W]),
      .threshold_i (thr_q),
`ifdef OUTPUT_THRESH_TILE_CLAMP_EN
      .mode_i      (mode_q),
`endif
      .pix_o       (lane_pix[l]),
      .hit_o       (hits[l])
    );
  end

  assign cnt_d  = cnt_q + CNT_W'(popcount(POPCNT_W'(hits)));
  // Address arithmetic wraps silently at 2^ADDR_W.
  assign addr_d = sa_q + aca_q + ADDR_W'(ADDR_OFFSET);

  // Control FSM with registered outputs; calc_en low freezes every non-IDLE state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      din_q   <= '0;
      thr_q   <= '0;
      sa_q    <= '0;
      aca_q   <= '0;
`ifdef OUTPUT_THRESH_TILE_CLAMP_EN
      mode_q  <= 1'b0;
`endif
      data_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            din_q   <= bus.data_in;
            thr_q   <= bus.threshold;
            sa_q    <= bus.start_addr;
            aca_q   <= bus.addr_calc_addr;
`ifdef OUTPUT_THRESH_TILE_CLAMP_EN
            mode_q  <= bus.mode;
`endif
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            step_q  <= '0;
            state_q <= ST_JUDGE;
          end
        end
        ST_JUDGE: begin
          if (bus.calc_en) begin
            for (int l = 0; l < LANES; l++) begin
              data_q[pix_idx[l]*OUT_W +: OUT_W] <= lane_pix[l];
            end
            cnt_q <= cnt_d;
            if (step_q == SW'(NSTEP - 1)) begin
              state_q <= ST_CALC;
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
        end
        ST_CALC: begin
          if (bus.calc_en) begin
            addr_q  <= addr_d;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.calc_en) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_o    = data_q;
  assign bus.fg_count  = cnt_q;
  assign bus.calc_addr = addr_q;
  assign bus.calc_done = done_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
